// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Reads a burst of consecutive DDR words over a request/grant,
//                in-order valid-return interface into the pixel line FIFO,
//                with a credit-limited skid buffer absorbing FIFO back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_WORDS    = 64,
    parameter int BYTES_PER_WORD = 4,
    parameter int SKID_DEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  go_fill_fifo,
    input  logic [31:0]           ddr_addr_to_read,
    output logic                  busy,
    output logic                  burst_done,
    output logic                  go_overrun,
    output logic                  rd_req,
    output logic [31:0]           rd_addr,
    input  logic                  rd_gnt,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_full
);

    localparam int c_CNT_W = $clog2(BURST_WORDS + 1);
    localparam int c_PTR_W = $clog2(SKID_DEPTH);
    localparam int c_CRD_W = $clog2(SKID_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_REQ  = c_CNT_W'(BURST_WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_BURST_LEN = c_CNT_W'(BURST_WORDS);
    localparam logic [c_CRD_W:0]   c_CREDITS   = (c_CRD_W + 1)'(SKID_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_base;
    logic [c_CNT_W-1:0]    r_req_cnt;
    logic [c_CNT_W-1:0]    r_wr_cnt;
    logic [c_CRD_W-1:0]    r_outstanding;
    logic                  r_go_overrun;
    logic [DATA_WIDTH-1:0] r_skid_mem [SKID_DEPTH];
    logic [c_PTR_W-1:0]    r_skid_wr_ptr;
    logic [c_PTR_W-1:0]    r_skid_rd_ptr;
    logic [c_CRD_W-1:0]    r_skid_cnt;

    logic                  w_credit;
    logic                  w_accept;
    logic                  w_rsp;
    logic                  w_skid_empty;
    logic                  w_start;

    // Outstanding reads plus buffered words never exceed the skid depth, so
    // every return that cannot be written immediately always has a slot.
    assign w_credit     = ({1'b0, r_outstanding} + {1'b0, r_skid_cnt}) < c_CREDITS;
    assign w_accept     = rd_req && rd_gnt;
    assign w_rsp        = rd_valid && (r_outstanding != '0);
    assign w_skid_empty = (r_skid_cnt == '0);
    assign w_start      = go_fill_fifo && (r_state == S_IDLE);

    assign rd_addr      = r_base + 32'(r_req_cnt) * 32'(BYTES_PER_WORD);
    assign fifo_wr_en   = !w_skid_empty && !fifo_full;
    assign fifo_wr_data = w_skid_empty ? '0 : r_skid_mem[r_skid_rd_ptr];
    assign go_overrun   = r_go_overrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        burst_done  = 1'b0;
        rd_req      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go_fill_fifo) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                busy   = 1'b1;
                rd_req = w_credit;
                if (w_credit && rd_gnt && (r_req_cnt == c_LAST_REQ)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_wr_cnt == c_BURST_LEN) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                burst_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base        <= '0;
            r_req_cnt     <= '0;
            r_wr_cnt      <= '0;
            r_outstanding <= '0;
            r_go_overrun  <= 1'b0;
            r_skid_wr_ptr <= '0;
            r_skid_rd_ptr <= '0;
            r_skid_cnt    <= '0;
        end else begin
            r_go_overrun <= go_fill_fifo && (r_state != S_IDLE);

            if (w_start) begin
                r_base    <= ddr_addr_to_read;
                r_req_cnt <= '0;
                r_wr_cnt  <= '0;
            end else begin
                if (w_accept) begin
                    r_req_cnt <= r_req_cnt + 1'b1;
                end
                if (fifo_wr_en) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end

            if (w_accept && !w_rsp) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_accept && w_rsp) begin
                r_outstanding <= r_outstanding - 1'b1;
            end

            if (w_rsp) begin
                r_skid_wr_ptr <= r_skid_wr_ptr + 1'b1;
            end
            if (fifo_wr_en) begin
                r_skid_rd_ptr <= r_skid_rd_ptr + 1'b1;
            end
            r_skid_cnt <= r_skid_cnt + c_CRD_W'(w_rsp) - c_CRD_W'(fifo_wr_en);
        end
    end

    // Storage needs no reset: the empty count masks stale entries.
    always_ff @(posedge clk) begin
        if (w_rsp) begin
            r_skid_mem[r_skid_wr_ptr] <= rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Randomised self-checking bench for fifo_burst_reader with a
//                DDR memory/responder model and burst-level expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int BPW = 4;
    localparam int SD  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          go_fill_fifo = 1'b0;
    logic [31:0]   ddr_addr_to_read = '0;
    logic          busy, burst_done, go_overrun, rd_req;
    logic [31:0]   rd_addr;
    logic          rd_gnt = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_full = 1'b0;

    fifo_burst_reader #(
        .DATA_WIDTH(DW), .BURST_WORDS(BW), .BYTES_PER_WORD(BPW), .SKID_DEPTH(SD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .go_fill_fifo(go_fill_fifo),
        .ddr_addr_to_read(ddr_addr_to_read), .busy(busy), .burst_done(burst_done),
        .go_overrun(go_overrun), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    rsp_t        resp_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] acc_log[$];
    logic [31:0] wr_log[$];
    logic [31:0] stall_log[$];
    int          done_cnt, done_bad, ovr_cnt, ovr_cyc, go_cyc, first_req_cyc, hold_viol;
    int          last_due = 0;
    int          lat_min = 2, lat_max = 2;
    bit          gnt_rand = 0, full_rand = 0;
    int          gnt_block_at = -1, gnt_block_len = 0;
    bit          prev_busy = 0, prev_wait = 0;
    logic [31:0] prev_addr = '0;

    // DDR contents: each word is random but fixed once first read.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // DDR responder and event recorder: drives returns just after the edge,
    // records what the design did just before the next one.
    initial begin : responder
        rsp_t r;
        int   d;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                rd_valid = 1'b1;
                rd_data  = resp_q[0].data;
                void'(resp_q.pop_front());
            end else begin
                rd_valid = 1'b0;
                rd_data  = $urandom;
            end
            if (gnt_block_len > 0 && acc_log.size() == gnt_block_at) begin
                rd_gnt = 1'b0;
                gnt_block_len--;
            end else begin
                rd_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (full_rand) fifo_full = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (reset_n) begin
                if (go_fill_fifo) go_cyc = cyc;
                if (rd_req && first_req_cyc < 0) first_req_cyc = cyc;
                if (prev_wait && (!rd_req || rd_addr !== prev_addr)) hold_viol++;
                prev_wait = rd_req && !rd_gnt;
                prev_addr = rd_addr;
                if (rd_req && !rd_gnt) stall_log.push_back(rd_addr);
                if (rd_req && rd_gnt) begin
                    acc_log.push_back(rd_addr);
                    d = cyc + $urandom_range(lat_min, lat_max);
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    r.due  = d;
                    r.data = mem_rd(rd_addr);
                    resp_q.push_back(r);
                end
                if (fifo_wr_en) wr_log.push_back(fifo_wr_data);
                if (burst_done) begin
                    done_cnt++;
                    if (busy || !prev_busy) done_bad++;
                end
                if (go_overrun) begin
                    ovr_cnt++;
                    ovr_cyc = cyc;
                end
                prev_busy = busy;
            end else begin
                prev_wait = 1'b0;
                prev_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
        $fatal(1);
    end

    task automatic clear_logs();
        acc_log.delete();
        wr_log.delete();
        stall_log.delete();
        done_cnt = 0; done_bad = 0; ovr_cnt = 0; hold_viol = 0;
        ovr_cyc = -1; go_cyc = -1; first_req_cyc = -1;
    endtask

    task automatic do_go(input logic [31:0] a);
        @(posedge clk); #1;
        go_fill_fifo = 1'b1;
        ddr_addr_to_read = a;
        @(posedge clk); #1;
        go_fill_fifo = 1'b0;
        ddr_addr_to_read = $urandom;
    endtask

    task automatic wait_done(input int target, input int budget, output bit to);
        to = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({busy, burst_done, go_overrun, rd_req, fifo_wr_en} !== 5'b0 ||
            rd_addr !== 32'h0 || fifo_wr_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=busy%b done%b ovr%b req%b wr%b addr=%h data=%h required=all zero",
                     busy, burst_done, go_overrun, rd_req, fifo_wr_en, rd_addr, fifo_wr_data);
        end
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got=busy%b req%b required=busy0 req0", busy, rd_req);
        end
    endtask

    task automatic test_basic_burst();
        bit          to;
        logic [31:0] base = 32'h8000_0000;
        logic [31:0] ea;
        lat_min = 2; lat_max = 2;
        clear_logs();
        do_go(base);
        wait_done(1, 300, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to) begin failures++; $display("FAIL basic_timeout got=no burst_done required=burst_done"); end
        checks++;
        if (first_req_cyc != go_cyc + 1) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=%0d", first_req_cyc - go_cyc, 1);
        end
        checks++;
        if (acc_log.size() != BW || wr_log.size() != BW) begin
            failures++;
            $display("FAIL basic_counts got=req%0d wr%0d required=%0d", acc_log.size(), wr_log.size(), BW);
        end
        for (int i = 0; i < BW && i < acc_log.size() && i < wr_log.size(); i++) begin
            ea = base + 32'(i * BPW);
            checks++;
            if (acc_log[i] !== ea || wr_log[i] !== mem_rd(ea)) begin
                failures++;
                $display("FAIL basic_word[%0d] got=addr%h data%h required=addr%h data%h",
                         i, acc_log[i], wr_log[i], ea, mem_rd(ea));
            end
        end
        checks++;
        if (done_cnt != 1 || done_bad != 0) begin
            failures++;
            $display("FAIL basic_done got=pulses%0d busy_err%0d required=pulses1 busy_err0", done_cnt, done_bad);
        end
    endtask

    task automatic test_fifo_full();
        bit          to;
        logic [31:0] base = 32'h8000_0000;
        logic [31:0] ea;
        clear_logs();
        fifo_full = 1'b1;
        do_go(base);
        repeat (19) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (acc_log.size() != SD || rd_req !== 1'b0 || wr_log.size() != 0) begin
            failures++;
            $display("FAIL full_credit got=accepts%0d req%b writes%0d required=accepts%0d req0 writes0",
                     acc_log.size(), rd_req, wr_log.size(), SD);
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        wait_done(1, 300, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || wr_log.size() != BW || done_cnt != 1) begin
            failures++;
            $display("FAIL full_complete got=writes%0d done%0d required=writes%0d done1", wr_log.size(), done_cnt, BW);
        end
        for (int i = 0; i < BW && i < wr_log.size(); i++) begin
            ea = base + 32'(i * BPW);
            checks++;
            if (wr_log[i] !== mem_rd(ea)) begin
                failures++;
                $display("FAIL full_data[%0d] got=%h required=%h", i, wr_log[i], mem_rd(ea));
            end
        end
    endtask

    task automatic test_gnt_stall();
        bit to;
        clear_logs();
        gnt_block_at = 1;
        gnt_block_len = 3;
        do_go(32'h8000_0000);
        wait_done(1, 300, to);
        repeat (5) @(negedge clk);
        checks++;
        if (stall_log.size() != 3 || hold_viol != 0) begin
            failures++;
            $display("FAIL stall_hold got=stalls%0d viol%0d required=stalls3 viol0", stall_log.size(), hold_viol);
        end
        for (int i = 0; i < stall_log.size(); i++) begin
            checks++;
            if (stall_log[i] !== 32'h8000_0004) begin
                failures++;
                $display("FAIL stall_addr[%0d] got=%h required=80000004", i, stall_log[i]);
            end
        end
        checks++;
        if (to || acc_log.size() != BW || wr_log.size() != BW || done_cnt != 1) begin
            failures++;
            $display("FAIL stall_complete got=req%0d wr%0d done%0d required=%0d/%0d/1",
                     acc_log.size(), wr_log.size(), done_cnt, BW, BW);
        end
    endtask

    task automatic test_overrun();
        bit          to;
        bit          seen_bad = 0;
        logic [31:0] base = 32'h8000_0000;
        clear_logs();
        do_go(base);
        for (int k = 0; k < 50 && acc_log.size() < 2; k++) begin
            @(negedge clk); #1;
        end
        do_go(32'h0000_1000);
        wait_done(1, 300, to);
        repeat (10) @(negedge clk);
        checks++;
        if (ovr_cnt != 1 || ovr_cyc != go_cyc + 1) begin
            failures++;
            $display("FAIL overrun_pulse got=pulses%0d at+%0d required=pulses1 at+1", ovr_cnt, ovr_cyc - go_cyc);
        end
        foreach (acc_log[i]) if (acc_log[i] !== base + 32'(i * BPW)) seen_bad = 1;
        checks++;
        if (to || seen_bad || acc_log.size() != BW || done_cnt != 1) begin
            failures++;
            $display("FAIL overrun_burst got=bad%0d req%0d done%0d required=bad0 req%0d done1",
                     seen_bad, acc_log.size(), done_cnt, BW);
        end
    endtask

    task automatic test_wrap();
        bit          to;
        logic [31:0] base = 32'hFFFF_FFF8;
        logic [31:0] ea;
        clear_logs();
        do_go(base);
        wait_done(1, 300, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || acc_log.size() != BW || wr_log.size() != BW) begin
            failures++;
            $display("FAIL wrap_counts got=req%0d wr%0d required=%0d", acc_log.size(), wr_log.size(), BW);
        end
        for (int i = 0; i < BW && i < acc_log.size() && i < wr_log.size(); i++) begin
            ea = base + 32'(i * BPW);
            checks++;
            if (acc_log[i] !== ea || wr_log[i] !== mem_rd(ea)) begin
                failures++;
                $display("FAIL wrap_word[%0d] got=addr%h data%h required=addr%h data%h",
                         i, acc_log[i], wr_log[i], ea, mem_rd(ea));
            end
        end
    endtask

    task automatic test_random();
        bit          to;
        logic [31:0] base;
        logic [31:0] ea;
        int          bad;
        for (int it = 0; it < 6; it++) begin
            clear_logs();
            base = $urandom & 32'hFFFF_FFFC;
            lat_min = 1; lat_max = $urandom_range(1, 5);
            gnt_rand = 1; full_rand = 1;
            do_go(base);
            wait_done(1, 800, to);
            gnt_rand = 0; full_rand = 0; fifo_full = 1'b0;
            repeat (8) @(negedge clk);
            bad = 0;
            for (int i = 0; i < BW && i < acc_log.size() && i < wr_log.size(); i++) begin
                ea = base + 32'(i * BPW);
                if (acc_log[i] !== ea || wr_log[i] !== mem_rd(ea)) bad++;
            end
            checks++;
            if (to || bad != 0 || acc_log.size() != BW || wr_log.size() != BW ||
                done_cnt != 1 || hold_viol != 0 || done_bad != 0) begin
                failures++;
                $display("FAIL random[%0d] got=bad%0d req%0d wr%0d done%0d viol%0d required=0/%0d/%0d/1/0",
                         it, bad, acc_log.size(), wr_log.size(), done_cnt, hold_viol, BW, BW);
            end
        end
        lat_min = 2; lat_max = 2;
    endtask

    task automatic test_back_to_back();
        bit          to;
        logic [31:0] a0 = 32'h0000_4000;
        logic [31:0] a1 = 32'h1234_5670;
        int          bad = 0;
        clear_logs();
        do_go(a0);
        wait_done(1, 300, to);
        do_go(a1);
        wait_done(2, 300, to);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 2 * BW && i < acc_log.size() && i < wr_log.size(); i++) begin
            if (acc_log[i] !== (i < BW ? a0 : a1) + 32'((i % BW) * BPW) ||
                wr_log[i] !== mem_rd((i < BW ? a0 : a1) + 32'((i % BW) * BPW))) bad++;
        end
        checks++;
        if (to || ovr_cnt != 0 || done_cnt != 2 || bad != 0 || acc_log.size() != 2 * BW) begin
            failures++;
            $display("FAIL b2b got=ovr%0d done%0d bad%0d req%0d required=ovr0 done2 bad0 req%0d",
                     ovr_cnt, done_cnt, bad, acc_log.size(), 2 * BW);
        end
    endtask

    task automatic test_reset_mid();
        bit          to;
        logic [31:0] base = 32'h0000_2000;
        logic [31:0] ea;
        clear_logs();
        lat_min = 5; lat_max = 5;
        do_go(32'h8000_0100);
        for (int k = 0; k < 50 && acc_log.size() < 3; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #3;
        checks++;
        if (busy !== 1'b1 || rd_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=busy%b req%b required=busy1 req1", busy, rd_req);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0 || fifo_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async got=busy%b req%b wr%b required=0 0 0", busy, rd_req, fifo_wr_en);
        end
        @(posedge clk); #3;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (wr_log.size() != 0 || busy !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL rstmid_stale got=writes%0d busy%b done%0d required=writes0 busy0 done0",
                     wr_log.size(), busy, done_cnt);
        end
        lat_min = 2; lat_max = 2;
        clear_logs();
        do_go(base);
        wait_done(1, 300, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || acc_log.size() != BW || wr_log.size() != BW || done_cnt != 1) begin
            failures++;
            $display("FAIL rstmid_clean got=req%0d wr%0d done%0d required=%0d/%0d/1",
                     acc_log.size(), wr_log.size(), done_cnt, BW, BW);
        end
        for (int i = 0; i < BW && i < acc_log.size() && i < wr_log.size(); i++) begin
            ea = base + 32'(i * BPW);
            checks++;
            if (acc_log[i] !== ea || wr_log[i] !== mem_rd(ea)) begin
                failures++;
                $display("FAIL rstmid_word[%0d] got=addr%h data%h required=addr%h data%h",
                         i, acc_log[i], wr_log[i], ea, mem_rd(ea));
            end
        end
    endtask

    initial begin : main
        test_reset();
        test_basic_burst();
        test_fifo_full();
        test_gnt_stall();
        test_overrun();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
